// File: rtl/sar_result_capture.sv
// sar_result_capture
//
// Rebuilds 12-bit SAR conversion results from the 6-bit inverted data bus.
// Each transfer is framed by clk_data: the rising edge carries the upper
// half and the falling edge carries the lower half. Completed results are
// queued in a small FIFO and drained through a valid/ready handshake.
//
// Optional feature macro: SAR_CAPTURE_TWOS_COMP_EN
//   defined   : differential results have bit 11 inverted (two's complement)
//   undefined : all results are offset binary, exactly as assembled
//
// Capture FSM states
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | no upper half held; a fall seen here is an orphan, ignored
//   HAVE_HI | upper half and mode latched, waiting for the lower half

module sar_result_capture #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_z,
    input  logic [5:0]                 data,
    input  logic                       clk_data,
    input  logic                       single_ended,
    output logic [11:0]                res_data,
    output logic                       res_se,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic                       overflow,
    input  logic                       clear_ovf,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        HAVE_HI = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic            clk_data_d;
    logic            rise;
    logic            fall;

    logic [5:0]      hi;
    logic            se;
    logic            load_hi;
    logic            push_req;
    logic [11:0]     code;

    logic [12:0]     mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [LW-1:0]   count;
    logic            full;
    logic            pop;
    logic            push_ok;

    // Delay the transfer frame by one cycle for edge detection
    always_ff @(posedge clk or negedge rst_z) begin
        if (!rst_z) begin
            clk_data_d <= 1'b0;
        end else begin
            clk_data_d <= clk_data;
        end
    end

    assign rise = clk_data & ~clk_data_d;
    assign fall = ~clk_data & clk_data_d;

    // FSM state register
    always_ff @(posedge clk or negedge rst_z) begin
        if (!rst_z) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a rise always (re)starts a result
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HAVE_HI;
                end
            end
            HAVE_HI: begin
                if (rise) begin
                    state_d = HAVE_HI;
                end else if (fall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: latch the upper half on any rise, push on a fall with a half held
    always_comb begin
        load_hi  = 1'b0;
        push_req = 1'b0;
        case (state_q)
            IDLE: begin
                load_hi = rise;
            end
            HAVE_HI: begin
                load_hi  = rise;
                push_req = fall;
            end
            default: begin
                load_hi  = 1'b0;
                push_req = 1'b0;
            end
        endcase
    end

    // Upper half and conversion mode, held until the lower half arrives
    always_ff @(posedge clk or negedge rst_z) begin
        if (!rst_z) begin
            hi <= 6'd0;
            se <= 1'b0;
        end else if (load_hi) begin
            hi <= ~data;
            se <= single_ended;
        end
    end

    // Assemble the result; single-ended MSB arrives as 1 and is forced to 0
    always_comb begin
        code = {hi, ~data};
        if (se) begin
            code[11] = 1'b0;
        end
`ifdef SAR_CAPTURE_TWOS_COMP_EN
        else begin
            code[11] = ~code[11];
        end
`endif
    end

    assign full    = (count == DEPTH_L);
    assign pop     = res_valid & res_ready;
    // When full, a same-cycle pop frees the slot the push lands in
    assign push_ok = push_req & (~full | pop);

    // FIFO storage; full-with-pop writes the slot being vacated
    always_ff @(posedge clk or negedge rst_z) begin
        if (!rst_z) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 13'd0;
            end
        end else if (push_ok) begin
            mem[wr_ptr] <= {se, code};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_z) begin
        if (!rst_z) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst_z) begin
        if (!rst_z) begin
            overflow <= 1'b0;
        end else if (push_req & full & ~pop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Head entry is read combinationally; stale while empty
    always_comb begin
        res_data  = mem[rd_ptr][11:0];
        res_se    = mem[rd_ptr][12];
        res_valid = (count != '0);
        level     = count;
    end

endmodule

// File: doc/sar_result_capture.md
# sar_result_capture

Downstream of the SAR state machine, this block rebuilds each 12-bit conversion result from the 6-bit `data` bus. The `clk_data` strobe frames each transfer. The block buffers completed results in a 4-entry FIFO and hands them to the digital back end over a valid/ready handshake. It runs on the same clock as the SAR state machine, and all inputs are synchronous to that clock.

## Interface
- `DEPTH`, default 4: number of FIFO entries; must be a power of 2, minimum 2.
- `clk`  in  1  system clock; same clock as the SAR state machine.
- `rst_z`  in  1  asynchronous, active-low reset.
- `data`  in  6  inverted result half from the SAR state machine.
- `clk_data`  in  1  transfer frame from the SAR state machine.
- `single_ended`  in  1  conversion mode; must be held stable for the whole conversion.
- `res_data`  out  12  result code at the FIFO head.
- `res_se`  out  1  single-ended flag of the FIFO head entry.
- `res_valid`  out  1  FIFO not empty.
- `res_ready`  in  1  consumer accepts the head entry when `res_valid` is also 1.
- `overflow`  out  1  sticky flag: a result was dropped because the FIFO was full.
- `clear_ovf`  in  1  synchronous clear of `overflow`.
- `level`  out  $clog2(DEPTH)+1  number of occupied FIFO entries.

## Operation
- `clk_data_d` is a register holding last cycle's `clk_data`.
  - Rise = `clk_data & ~clk_data_d`.
  - Fall = `~clk_data & clk_data_d`.
- Capture FSM:
  - States are IDLE and HAVE_HI.
  - IDLE, on rise: latch `hi <= ~data`, latch `se <= single_ended`, go to HAVE_HI.
  - HAVE_HI, on rise: re-latch `hi` and `se`, stay in HAVE_HI. This is a restart; the old half is discarded.
  - HAVE_HI, on fall: assemble `code = {hi, ~data}`, push it, return to IDLE.
  - IDLE, on fall: ignored. This is an orphan lower half, for example after a reset mid-conversion.
- Single-ended correction: if `se` = 1, `code[11]` is forced to 0. On the data bus this bit arrives as 1 by construction.
- FIFO storage:
  - Each entry is 13 bits, `{se, code}`.
  - Write and read pointers are `$clog2(DEPTH)` bits, wrap modulo DEPTH, plus an occupancy count.
- Push:
  - If `level` < DEPTH, the entry is written.
  - If `level` = DEPTH and no pop occurs in the same cycle, the entry is dropped and `overflow` is set.
- Pop: occurs when `res_valid & res_ready`. A pop while empty is impossible because `res_valid` = 0.
- Simultaneous push and pop:
  - With the FIFO full: the push succeeds, `level` is unchanged, and no overflow occurs.
  - At any other level: `level` is unchanged.
- `overflow`: set-dominant. If set and `clear_ovf` occur in the same cycle, `overflow` ends at 1.
- `res_data` and `res_se` are combinational reads of the head entry.
  - While `res_valid` = 0 they show the stale slot content; the consumer must ignore them.

## Timing
- Reset values:
  - FSM = IDLE; `hi`, `se` and `clk_data_d` = 0; pointers and `level` = 0.
  - `res_valid` = 0, `overflow` = 0, `res_data` = 0, `res_se` = 0. Storage is reset to 0.
- `data` is sampled in the same cycle the rise or fall is detected:
  - The rise cycle sees the upper half.
  - The fall cycle sees the final lower half, because the SAR state machine has just returned to idle and holds the result.
- Latency: `res_valid` goes to 1 on the clock edge that ends the fall cycle, i.e. 1 cycle after `clk_data` is sampled low.
- Throughput: one result per conversion. The FIFO and FSM can accept back-to-back conversions separated by a single idle cycle.
- `level` updates on the same edge as the push or pop.
- Reset asserted mid-conversion clears everything immediately. A fall arriving afterwards is ignored because the FSM is in IDLE.

## Configuration
- Macro: `SAR_CAPTURE_TWOS_COMP_EN`.
- Defined: differential entries (`se` = 0) have `code[11]` inverted before the push, so `res_data` is two's complement centred at 0. Single-ended entries are unchanged.
- Undefined: all codes are offset binary, exactly as assembled.

## Test plan
- Differential conversion, result 0xA5C:
  - Stimulus: `data` = 0x16 at rise, `data` = 0x23 at fall.
  - Response: `res_data` = 0xA5C, `res_se` = 0, `res_valid` 1 cycle after the fall. With the macro defined, `res_data` = 0x25C.
- Single-ended conversion, result 0x3FF:
  - Stimulus: `single_ended` = 1, `data` = 0x10 at rise, 0x00 at fall.
  - Response: `res_data` = 0x3FF, `res_se` = 1. Identical result with the macro defined.
- Overflow:
  - Stimulus: 5 conversions with `res_ready` = 0.
  - Response: `level` = 4, `overflow` = 1, and the first 4 results are popped in order. Then raise `clear_ovf` with no push that cycle → `overflow` = 0.
- Full FIFO with a simultaneous pop:
  - Stimulus: FIFO full, a push and a pop in the same cycle.
  - Response: `level` stays 4, `overflow` stays 0, and the new entry is popped last.
- Reset and orphan halves:
  - Stimulus: pulse `rst_z` low between the rise and the fall.
  - Response: no push, and `res_valid` stays 0. An orphan fall seen from IDLE → no push.
- Restart:
  - Stimulus: two rises without a fall in between.
  - Response: the second upper half is used in the assembled result.
